settable_clock: RTL and testbench
=================================

# settable_clock

Parametrised time-of-day core that replaces the separate divider and counter pair: it generates its own one-second tick, keeps hours/minutes/seconds in 24 h or 12 h format, and adds a set-time state machine driven by the debounced increment, decrement and mode buttons. It sits between the debounce instances and the display driver in the top level; its outputs feed digit formatting directly, and `blink_o` drives digit blanking of the field being edited.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per second; ≥ 2.
- `HOUR_MODE`, 24: 24 gives hours 0..23; 12 gives hours 1..12 with `pm_o`.
- `BLINK_DIV`, 25_000_000: cycles per `blink_o` half-period; ≥ 1.
- `REPEAT_DELAY`, 50_000_000: hold cycles before the first auto-repeat step; `AUTOREPEAT_EN` only.
- `REPEAT_DIV`, 10_000_000: cycles between auto-repeat steps; `AUTOREPEAT_EN` only.

Ports:
- `clk_100MHz_i`  in  1  system clock, the only clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `inc_i`  in  1  debounced increment level.
- `dec_i`  in  1  debounced decrement level.
- `mode_i`  in  1  debounced mode level.
- `seconds_o`  out  6  seconds, 0..59.
- `minutes_o`  out  6  minutes, 0..59.
- `hours_o`  out  5  hours, 0..23 or 1..12.
- `pm_o`  out  1  PM flag; constant 0 when HOUR_MODE=24.
- `mode_o`  out  2  state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- `second_o`  out  1  one-cycle pulse per counted second.
- `blink_o`  out  1  edit-field blink phase; 0 in RUN.

## Operation
- Reset values: time 00:00:00 (24 h) or 12:00:00 with `pm_o`=0 (12 h). `mode_o`=RUN, `second_o`=0, `blink_o`=0. All internal counters and edge registers are cleared.
- Each input is registered once. An event is `x_i & ~x_q`, a rising edge.
- The FSM advances on a mode event: RUN → SET_H → SET_M → SET_S → RUN.
- RUN:
  - The tick counter counts 0..TICK_DIV-1.
  - At terminal count the seconds value increments. Carries ripple 59→0 into minutes, and 59→0 into hours.
  - Hours wrap 23→0 in 24 h mode. In 12 h mode the sequence is 11→12 with `pm_o` toggled, then 12→1.
  - Inc and dec events are ignored.
- SET states:
  - Time and the tick counter are frozen. The tick counter is held at 0, so the first second after returning to RUN is a full TICK_DIV cycles.
  - An inc event steps the selected field +1 with wrap; a dec event steps it −1 with wrap. There is no carry into other fields.
  - In 12 h mode, SET_H steps through 24 positions (12AM, 1AM..11AM, 12PM..11PM), toggling `pm_o` at the 11↔12 boundary.
  - Seconds wrap 59↔0, minutes wrap 59↔0.
- Simultaneous events in the same cycle:
  - inc and dec together: both are ignored.
  - mode with inc or dec: mode wins and the step is discarded.
  - mode with a RUN terminal count: the second is still counted, then the state changes.
- Blink:
  - On entry to any SET state, `blink_o`=1 and the blink counter is cleared.
  - `blink_o` toggles every BLINK_DIV cycles.
  - On return to RUN, `blink_o` is forced to 0.
- Reset asserted mid-operation takes effect immediately, returning all state to reset values regardless of state.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Edge latency: with `inc_i` first sampled high at edge n, the event is detected at edge n+1 and the field changes at the output after edge n+1. Mode events have the same latency.
- Ticks: `second_o` is high for exactly one cycle, the same cycle in which the updated time first appears. Pulses are TICK_DIV cycles apart in RUN; there are no pulses in SET states.
- A level held high produces one event only, unless AUTOREPEAT_EN applies.

## Configuration
- `SETTABLE_CLOCK_AUTOREPEAT_EN` defined:
  - In a SET state, holding `inc_i` or `dec_i` (the other low) for REPEAT_DELAY cycles after the initial step produces a further step.
  - Further steps then follow every REPEAT_DIV cycles while the button stays held.
  - Release, a mode change, or both buttons high stops repetition and clears the repeat counter.
- Undefined: edges only; the REPEAT_* parameters are unused and the repeat counter is not synthesised.

## Test plan
- Reset, then release with TICK_DIV=10, HOUR_MODE=24 → time 00:00:00; `second_o` pulses every 10 cycles; first pulse 10 cycles after reset release; seconds=1.
- Preload 23:59:59 via the SET states, return to RUN → at the next `second_o`, time is 00:00:00.
- HOUR_MODE=12, preload 11:59:59 AM → at the next pulse, 12:00:00 with `pm_o`=1.
- HOUR_MODE=12, continue from 12:59:59 PM → at the next pulse, 1:00:00 with `pm_o`=1.
- Three mode pulses → SET_S; dec at seconds=0 → 59, with minutes and hours unchanged. Then:
  - inc and dec together → no change.
  - mode with inc → RUN, value unchanged.
- SET_M with BLINK_DIV=4 → `blink_o`=1 for 4 cycles, then 0 for 4 cycles; entering RUN forces 0.
- With AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_DIV=3, in SET_M at minutes=5, hold `inc_i` for 20 cycles → minutes=6 after the initial step, 7 at +8 cycles, then +1 every 3 cycles. Without the macro → minutes=6 only.

Source files
------------

// File: rtl/settable_clock.sv
// settable_clock: time-of-day core with its own one-second tick, 24 h or 12 h
// hour format, and a button-driven set-time state machine.
//
// Parameters:
//   TICK_DIV     clock cycles per second (>= 2)
//   HOUR_MODE    24 -> hours 0..23, 12 -> hours 1..12 with pm_o
//   BLINK_DIV    cycles per blink_o half-period (>= 1)
//   REPEAT_DELAY hold cycles before the first auto-repeat step (auto-repeat only)
//   REPEAT_DIV   cycles between further auto-repeat steps (auto-repeat only)
//
// Ports:
//   clk_100MHz_i  system clock
//   reset_i       asynchronous active-low reset
//   inc_i/dec_i   debounced increment / decrement levels
//   mode_i        debounced mode level (RUN -> SET_H -> SET_M -> SET_S -> RUN)
//   seconds_o     0..59
//   minutes_o     0..59
//   hours_o       0..23 (24 h) or 1..12 (12 h)
//   pm_o          PM flag, constant 0 in 24 h mode
//   mode_o        0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   second_o      one-cycle pulse when a counted second appears on the outputs
//   blink_o       blink phase for the field being edited, 0 in RUN
//
// Build option: define SETTABLE_CLOCK_AUTOREPEAT_EN to enable auto-repeat of a
// held inc/dec button in the SET states. Without it, only edges step a field.
module settable_clock #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned HOUR_MODE    = 24,
  parameter int unsigned BLINK_DIV    = 25_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_DIV   = 10_000_000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       mode_i,
  output logic [5:0] seconds_o,
  output logic [5:0] minutes_o,
  output logic [4:0] hours_o,
  output logic       pm_o,
  output logic [1:0] mode_o,
  output logic       second_o,
  output logic       blink_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SET_H = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;
  localparam logic [1:0] ST_SET_S = 2'd3;

  localparam bit          H12        = (HOUR_MODE == 12);
  localparam int unsigned TW         = $clog2(TICK_DIV);
  localparam int unsigned BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    HOUR_RST   = H12 ? 5'd12 : 5'd0;

  // Input sampling and edge detection
  logic inc_q, dec_q, mode_q;
  logic inc_last_q, dec_last_q, mode_last_q;
  logic inc_ev, dec_ev, mode_ev;
  logic single_inc, single_dec;
  logic rep_fire, rep_up;

  // Time and control state
  logic [1:0]    state_q, state_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          pm_q, pm_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          pulse_q, pulse_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          step_up, step_dn;

  always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      mode_q      <= 1'b0;
      inc_last_q  <= 1'b0;
      dec_last_q  <= 1'b0;
      mode_last_q <= 1'b0;
    end else begin
      inc_q       <= inc_i;
      dec_q       <= dec_i;
      mode_q      <= mode_i;
      inc_last_q  <= inc_q;
      dec_last_q  <= dec_q;
      mode_last_q <= mode_q;
    end
  end

  // Edges are taken on the registered levels so every event acts one edge
  // after the button is first sampled high.
  assign inc_ev  = inc_q  & ~inc_last_q;
  assign dec_ev  = dec_q  & ~dec_last_q;
  assign mode_ev = mode_q & ~mode_last_q;

  // A step needs exactly one of inc/dec, and a mode event discards it.
  assign single_inc = inc_ev & ~dec_ev & ~mode_ev;
  assign single_dec = dec_ev & ~inc_ev & ~mode_ev;

  // Hour stepping, returns {pm, hour}. The 12 h sequence 12,1..11 per half-day
  // toggles pm at the 11<->12 boundary in either direction.
  function automatic logic [5:0] hour_up(input logic [4:0] h, input logic pm);
    if (H12) begin
      if (h == 5'd11)      return {~pm, 5'd12};
      else if (h == 5'd12) return {pm, 5'd1};
      else                 return {pm, h + 5'd1};
    end else begin
      if (h == 5'd23)      return {1'b0, 5'd0};
      else                 return {1'b0, h + 5'd1};
    end
  endfunction

  function automatic logic [5:0] hour_dn(input logic [4:0] h, input logic pm);
    if (H12) begin
      if (h == 5'd12)      return {~pm, 5'd11};
      else if (h == 5'd1)  return {pm, 5'd12};
      else                 return {pm, h - 5'd1};
    end else begin
      if (h == 5'd0)       return {1'b0, 5'd23};
      else                 return {1'b0, h - 5'd1};
    end
  endfunction

  function automatic logic [5:0] wrap60_up(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap60_dn(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

`ifdef SETTABLE_CLOCK_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_DIV) ? REPEAT_DELAY : REPEAT_DIV;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] DIV_LAST   = RW'(REPEAT_DIV - 1);

  logic          rep_arm_q, rep_arm_d;
  logic          rep_up_q, rep_up_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_held;

  assign rep_held = rep_up_q ? (inc_q & ~dec_q) : (dec_q & ~inc_q);
  assign rep_up   = rep_up_q;

  // Armed by an accepted edge step; counts the initial delay first, then the
  // repeat period, for as long as the same button stays held alone.
  always_comb begin
    rep_arm_d   = rep_arm_q;
    rep_up_d    = rep_up_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    rep_fire    = 1'b0;
    if (state_q == ST_RUN || mode_ev) begin
      rep_arm_d = 1'b0;
      rep_cnt_d = '0;
    end else if (single_inc || single_dec) begin
      rep_arm_d   = 1'b1;
      rep_up_d    = single_inc;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (rep_arm_q) begin
      if (!rep_held) begin
        rep_arm_d = 1'b0;
        rep_cnt_d = '0;
      end else if (rep_cnt_q == (rep_first_q ? DELAY_LAST : DIV_LAST)) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      rep_arm_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_arm_q   <= rep_arm_d;
      rep_up_q    <= rep_up_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_DIV)};
  assign rep_fire = 1'b0;
  assign rep_up   = 1'b0;
`endif

  assign step_up = single_inc | (rep_fire & rep_up);
  assign step_dn = single_dec | (rep_fire & ~rep_up);

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    pm_d        = pm_q;
    tick_d      = tick_q;
    pulse_d     = 1'b0;
    blink_d     = 1'b0;
    blink_cnt_d = '0;

    if (state_q == ST_RUN) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        pulse_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d          = 6'd0;
            {pm_d, hour_d} = hour_up(hour_q, pm_q);
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end else begin
      tick_d = '0;
      case (state_q)
        ST_SET_H: begin
          if (step_up)      {pm_d, hour_d} = hour_up(hour_q, pm_q);
          else if (step_dn) {pm_d, hour_d} = hour_dn(hour_q, pm_q);
        end
        ST_SET_M: begin
          if (step_up)      min_d = wrap60_up(min_q);
          else if (step_dn) min_d = wrap60_dn(min_q);
        end
        default: begin
          if (step_up)      sec_d = wrap60_up(sec_q);
          else if (step_dn) sec_d = wrap60_dn(sec_q);
        end
      endcase

      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end

    // Mode change is applied after any RUN second so a coincident tick is kept.
    if (mode_ev) begin
      tick_d      = '0;
      blink_cnt_d = '0;
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
      blink_d = (state_d != ST_RUN);
    end
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_RUN;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= HOUR_RST;
      pm_q        <= 1'b0;
      tick_q      <= '0;
      pulse_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      tick_q      <= tick_d;
      pulse_q     <= pulse_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign seconds_o = sec_q;
  assign minutes_o = min_q;
  assign hours_o   = hour_q;
  assign pm_o      = pm_q;
  assign mode_o    = state_q;
  assign second_o  = pulse_q;
  assign blink_o   = blink_q;

endmodule

// File: tb/tb_settable_clock.sv
// Testbench for settable_clock: a 24 h and a 12 h instance share one set of
// button inputs and are compared each cycle against a time-of-day model.
module tb_settable_clock;

  localparam int TICK   = 10;
  localparam int BLINK  = 4;
  localparam int RDELAY = 8;
  localparam int RDIV   = 3;
`ifdef SETTABLE_CLOCK_AUTOREPEAT_EN
  localparam bit AR      = 1'b1;
  localparam int RPT_MIN = 10;
`else
  localparam bit AR      = 1'b0;
  localparam int RPT_MIN = 6;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic inc_i, dec_i, mode_i;
  logic [5:0] s24, m24, s12, m12;
  logic [4:0] h24, h12;
  logic       pm24, pm12, sec24, sec12, bl24, bl12;
  logic [1:0] md24, md12;

  always #5 clk = ~clk;

  settable_clock #(.TICK_DIV(TICK), .HOUR_MODE(24), .BLINK_DIV(BLINK),
                   .REPEAT_DELAY(RDELAY), .REPEAT_DIV(RDIV)) u_dut24 (
    .clk_100MHz_i(clk), .reset_i(rst_n), .inc_i(inc_i), .dec_i(dec_i), .mode_i(mode_i),
    .seconds_o(s24), .minutes_o(m24), .hours_o(h24), .pm_o(pm24),
    .mode_o(md24), .second_o(sec24), .blink_o(bl24));

  settable_clock #(.TICK_DIV(TICK), .HOUR_MODE(12), .BLINK_DIV(BLINK),
                   .REPEAT_DELAY(RDELAY), .REPEAT_DIV(RDIV)) u_dut12 (
    .clk_100MHz_i(clk), .reset_i(rst_n), .inc_i(inc_i), .dec_i(dec_i), .mode_i(mode_i),
    .seconds_o(s12), .minutes_o(m12), .hours_o(h12), .pm_o(pm12),
    .mode_o(md12), .second_o(sec12), .blink_o(bl12));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time kept as 24 h hour/minute/second; the 12 h view is derived.
  int t_h, t_m, t_s, t_md, cyc, run_start, set_entry, arm_edge;
  bit exp_pulse, armed, arm_up;
  bit lv1_i, lv1_d, lv1_m, lv2_i, lv2_d, lv2_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    t_h = 0; t_m = 0; t_s = 0; t_md = 0;
    cyc = 0; run_start = 0; set_entry = 0; arm_edge = 0;
    exp_pulse = 0; armed = 0; arm_up = 0;
    lv1_i = 0; lv1_d = 0; lv1_m = 0; lv2_i = 0; lv2_d = 0; lv2_m = 0;
  endfunction

  function automatic void m_adv_sec();
    t_s++;
    if (t_s == 60) begin
      t_s = 0;
      t_m++;
      if (t_m == 60) begin
        t_m = 0;
        t_h = (t_h + 1) % 24;
      end
    end
  endfunction

  function automatic void m_step(input bit up);
    case (t_md)
      1: t_h = (t_h + (up ? 1 : 23)) % 24;
      2: t_m = (t_m + (up ? 1 : 59)) % 60;
      default: t_s = (t_s + (up ? 1 : 59)) % 60;
    endcase
  endfunction

  // One clock edge: an input level sampled at edge k acts at edge k+1.
  function automatic void m_edge(input bit li, input bit ld, input bit lm);
    bit ei, ed, em, held;
    cyc++;
    ei = lv1_i & ~lv2_i;
    ed = lv1_d & ~lv2_d;
    em = lv1_m & ~lv2_m;
    exp_pulse = 0;
    if (t_md == 0) begin
      if ((cyc - run_start) % TICK == 0) begin
        m_adv_sec();
        exp_pulse = 1;
      end
      if (em) begin
        t_md = 1;
        set_entry = cyc;
      end
    end else if (em) begin
      t_md = (t_md + 1) % 4;
      armed = 0;
      if (t_md == 0) run_start = cyc;
      else set_entry = cyc;
    end else if (ei ^ ed) begin
      m_step(ei);
      armed = AR;
      arm_up = ei;
      arm_edge = cyc;
    end else if (armed) begin
      held = arm_up ? (lv1_i & ~lv1_d) : (lv1_d & ~lv1_i);
      if (!held) armed = 0;
      else if (cyc - arm_edge >= RDELAY && (cyc - arm_edge - RDELAY) % RDIV == 0)
        m_step(arm_up);
    end
    lv2_i = lv1_i; lv2_d = lv1_d; lv2_m = lv1_m;
    lv1_i = li;    lv1_d = ld;    lv1_m = lm;
  endfunction

  task automatic compare_all();
    int hv12, bl;
    hv12 = (t_h % 12 == 0) ? 12 : t_h % 12;
    bl = (t_md != 0 && ((cyc - set_entry) / BLINK) % 2 == 0) ? 1 : 0;
    check_eq("sec24", s24, t_s);
    check_eq("min24", m24, t_m);
    check_eq("hour24", h24, t_h);
    check_eq("pm24", pm24, 0);
    check_eq("mode24", md24, t_md);
    check_eq("tick24", sec24, exp_pulse);
    check_eq("blink24", bl24, bl);
    check_eq("sec12", s12, t_s);
    check_eq("min12", m12, t_m);
    check_eq("hour12", h12, hv12);
    check_eq("pm12", pm12, (t_h >= 12) ? 1 : 0);
    check_eq("mode12", md12, t_md);
    check_eq("tick12", sec12, exp_pulse);
    check_eq("blink12", bl12, bl);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic i, input logic d, input logic m);
    inc_i = i; dec_i = d; mode_i = m;
    @(posedge clk);
    m_edge(i, d, m);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic press(input logic i, input logic d, input logic m);
    cycle(i, d, m);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_pulse();
    bit seen;
    seen = 0;
    for (int k = 0; k < 3 * TICK && !seen; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (sec24 === 1'b1) seen = 1;
    end
    check_eq("pulse_seen", seen, 1);
  endtask

  task automatic preload(input int hh, input int mm, input int ss);
    press(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 24 && t_h != hh; k++) press(t_h < hh, t_h > hh, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 60 && t_m != mm; k++) press(t_m < mm, t_m > mm, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 60 && t_s != ss; k++) press(t_s < ss, t_s > ss, 1'b0);
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0; inc_i = 1'b0; dec_i = 1'b0; mode_i = 1'b0;
    #1;
    m_reset();
    compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sm, sh;
    logic ri, rd, rm;
    rst_n = 1'b0; inc_i = 1'b0; dec_i = 1'b0; mode_i = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Free run: pulses at 10 and 20 cycles after release.
    repeat (25) cycle(1'b0, 1'b0, 1'b0);
    check_eq("run_seconds", s24, 2);

    // 23:59:59 -> 00:00:00 (12 h view: 11:59:59 PM -> 12:00:00 AM)
    preload(23, 59, 59);
    wait_pulse();
    check_eq("wrap24_hour", h24, 0);
    check_eq("wrap24_min", m24, 0);
    check_eq("wrap24_sec", s24, 0);
    check_eq("wrap12_hour", h12, 12);
    check_eq("wrap12_pm", pm12, 0);

    // 11:59:59 AM -> 12:00:00 PM
    preload(11, 59, 59);
    wait_pulse();
    check_eq("noon12_hour", h12, 12);
    check_eq("noon12_pm", pm12, 1);
    check_eq("noon24_hour", h24, 12);

    // 12:59:59 PM -> 1:00:00 PM
    preload(12, 59, 59);
    wait_pulse();
    check_eq("one12_hour", h12, 1);
    check_eq("one12_pm", pm12, 1);
    check_eq("one24_hour", h24, 13);

    // SET_S: dec wraps 0 -> 59 without carry, inc+dec ignored, mode beats inc.
    repeat (3) press(1'b0, 1'b0, 1'b1);
    check_eq("set_s_mode", md24, 3);
    for (int k = 0; k < 60 && t_s != 0; k++) press(1'b0, 1'b1, 1'b0);
    sm = t_m; sh = t_h;
    press(1'b0, 1'b1, 1'b0);
    check_eq("dec_wrap_sec", s24, 59);
    check_eq("dec_wrap_min", m24, sm);
    check_eq("dec_wrap_hour", h24, sh);
    press(1'b1, 1'b1, 1'b0);
    check_eq("both_ignored", s24, 59);
    press(1'b1, 1'b0, 1'b1);
    check_eq("mode_wins_state", md24, 0);
    check_eq("mode_wins_sec", s24, 59);

    // SET_M: blink phase followed cycle by cycle, then minutes to 5 and hold inc.
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 60 && t_m != 5; k++) press(t_m < 5, t_m > 5, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check_eq("hold_minutes", m24, RPT_MIN);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    check_eq("run_blink_off", bl24, 0);

    // Random button activity with one asynchronous reset in the middle.
    ri = 1'b0; rd = 1'b0; rm = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) mid_reset();
      if ($urandom_range(7) == 0) ri = ~ri;
      if ($urandom_range(7) == 0) rd = ~rd;
      if ($urandom_range(11) == 0) rm = ~rm;
      cycle(ri, rd, rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
